// File: rtl/trap_ctrl.sv
// trap_ctrl: trap and return controller for the 5-stage pipeline.
// Takes external interrupts, illegal instructions and ECALLs at EX, records
// the return PC / cause in sepc / scause, and emits one-cycle redirect pulses
// for the next-PC mux.
//
// Build option: define TRAP_IRQ_SYNC_EN to pass ext_irq through a 2-flop
// synchroniser before edge detection (ext_irq -> irq_pend latency 3 cycles
// instead of 1).
//
// Handshake note: there is no valid/ready pair here. pc_write acts as the
// "advance" qualifier: an event is consumed only in a cycle with pc_write=1,
// and EX holds (re-presents) the same event for as long as pc_write=0. A
// redirect pulse flushes EX, so no event is consumed while flush is high.
module trap_ctrl #(
  parameter logic [31:0] CAUSE_IRQ   = 32'h1,
  parameter logic [31:0] CAUSE_ILL   = 32'h2,
  parameter logic [31:0] CAUSE_ECALL = 32'h8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ext_irq,
  input  logic        ex_valid,
  input  logic [31:0] pc_ex,
  input  logic        ecall_ex,
  input  logic        illegal_ex,
  input  logic        mret_ex,
  input  logic        pc_write,
  output logic [31:0] sepc,
  output logic [31:0] scause,
  output logic        trap_req,
  output logic        int_take,
  output logic        mret_take,
  output logic        in_handler,
  output logic        flush
);

  typedef enum logic {S_RUN = 1'b0, S_TRAP = 1'b1} state_t;

  state_t state;
  logic   irq_s;
  logic   irq_d;
  logic   irq_rise;
  logic   irq_pend;

`ifdef TRAP_IRQ_SYNC_EN
  logic irq_sync1;
  logic irq_sync2;

  // Two-flop synchroniser for the asynchronous interrupt line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_sync1 <= 1'b0;
      irq_sync2 <= 1'b0;
    end else begin
      irq_sync1 <= ext_irq;
      irq_sync2 <= irq_sync1;
    end
  end

  assign irq_s = irq_sync2;
`else
  assign irq_s = ext_irq;
`endif

  // Delayed copy of the interrupt line for rising-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_d <= 1'b0;
    else       irq_d <= irq_s;
  end

  assign irq_rise = irq_s & ~irq_d;

  // Event decode. Interrupts need no valid EX instruction (the EX slot is
  // squashed and its PC becomes the return address); exceptions do.
  logic run;
  logic accept;
  logic take_irq;
  logic exc_ok;
  logic take_ill;
  logic take_ecall;
  logic take_mret;

  assign run        = (state == S_RUN);
  assign accept     = pc_write & ~flush;
  assign take_irq   = accept & run & irq_pend;
  assign exc_ok     = accept & ex_valid & ~take_irq;
  // MRET outside a handler is treated as an illegal instruction.
  assign take_ill   = exc_ok & (illegal_ex | (mret_ex & run));
  assign take_ecall = exc_ok & ~take_ill & ecall_ex;
  // MRET with sepc==0 is a deliberate no-op (no valid return address).
  assign take_mret  = exc_ok & ~take_ill & ~ecall_ex & mret_ex & ~run
                      & (sepc != 32'd0);

  // Pending-interrupt flag: a new edge beats a same-cycle take.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_pend <= 1'b0;
    else       irq_pend <= irq_rise | (irq_pend & ~take_irq);
  end

  // FSM, trap CSRs and registered redirect pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_RUN;
      sepc      <= 32'd0;
      scause    <= 32'd0;
      trap_req  <= 1'b0;
      int_take  <= 1'b0;
      mret_take <= 1'b0;
    end else begin
      trap_req  <= take_irq | take_ill | take_ecall;
      int_take  <= take_irq;
      mret_take <= take_mret;
      if (take_irq) begin
        sepc   <= pc_ex;
        scause <= CAUSE_IRQ;
        state  <= S_TRAP;
      end else if (take_ill) begin
        sepc   <= pc_ex + 32'd4;
        scause <= CAUSE_ILL;
        state  <= S_TRAP;
      end else if (take_ecall) begin
        sepc   <= pc_ex + 32'd4;
        scause <= CAUSE_ECALL;
        state  <= S_TRAP;
      end else if (take_mret) begin
        state  <= S_RUN;
      end
    end
  end

  assign in_handler = (state == S_TRAP);
  assign flush      = trap_req | mret_take;

endmodule

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl: directed vectors with a scoreboard of expected
// redirect pulses (fields + arrival cycle) checked by an independent monitor.
module tb_trap_ctrl;

  localparam int W = 68;  // {trap_req, int_take, mret_take, in_handler, sepc, scause}
`ifdef TRAP_IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ext_irq = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] pc_ex = 32'd0;
  logic        ecall_ex = 1'b0;
  logic        illegal_ex = 1'b0;
  logic        mret_ex = 1'b0;
  logic        pc_write = 1'b0;
  logic [31:0] sepc;
  logic [31:0] scause;
  logic        trap_req;
  logic        int_take;
  logic        mret_take;
  logic        in_handler;
  logic        flush;

  trap_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .ext_irq    (ext_irq),
    .ex_valid   (ex_valid),
    .pc_ex      (pc_ex),
    .ecall_ex   (ecall_ex),
    .illegal_ex (illegal_ex),
    .mret_ex    (mret_ex),
    .pc_write   (pc_write),
    .sepc       (sepc),
    .scause     (scause),
    .trap_req   (trap_req),
    .int_take   (int_take),
    .mret_take  (mret_take),
    .in_handler (in_handler),
    .flush      (flush)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  function automatic logic [W-1:0] mk(input logic tr, input logic it, input logic mt,
                                      input logic ih, input logic [31:0] ep,
                                      input logic [31:0] ec);
    return {tr, it, mt, ih, ep, ec};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic pw, input logic v, input logic [31:0] pc,
                        input logic ec, input logic il, input logic mr);
    pc_write   = pw;
    ex_valid   = v;
    pc_ex      = pc;
    ecall_ex   = ec;
    illegal_ex = il;
    mret_ex    = mr;
  endtask

  // Queue an expected pulse lat cycles after the current cycle.
  task automatic expect_pulse(input logic [W-1:0] rec, input int lat);
    exp_q.push_back(rec);
    cyc_q.push_back(cyc + lat);
  endtask

  // Issue the currently driven event, then a quiet cycle while the pulse is up.
  task automatic fire(input logic [W-1:0] rec);
    expect_pulse(rec, 1);
    step(1);
    set_in(1'b1, 1'b0, pc_ex, 1'b0, 1'b0, 1'b0);
    step(1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] req;
    int           req_cyc;
    if (rstn && (trap_req || int_take || mret_take)) begin
      act = {trap_req, int_take, mret_take, in_handler, sepc, scause};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got %h at cycle %0d, expected no pulse", act, cyc);
      end else begin
        req     = exp_q.pop_front();
        req_cyc = cyc_q.pop_front();
        if (act !== req || cyc != req_cyc || flush !== 1'b1) begin
          n_err++;
          $display("FAIL pulse: got %h flush=%b at cycle %0d, expected %h flush=1 at cycle %0d",
                   act, flush, cyc, req, req_cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    step(2);
    check("rst_sepc", sepc, 32'd0);
    check("rst_scause", scause, 32'd0);
    check("rst_trap_req", {31'd0, trap_req}, 32'd0);
    check("rst_int_take", {31'd0, int_take}, 32'd0);
    check("rst_mret_take", {31'd0, mret_take}, 32'd0);
    check("rst_in_handler", {31'd0, in_handler}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    rstn = 1'b1;
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(2);

    // ECALL at 0x100, then MRET back
    set_in(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    fire(mk(1, 0, 0, 1, 32'h104, 32'h8));
    check("ecall_in_handler", {31'd0, in_handler}, 32'd1);
    set_in(1'b1, 1'b1, 32'h150, 1'b0, 1'b0, 1'b1);
    fire(mk(0, 0, 1, 0, 32'h104, 32'h8));
    check("mret_back_to_run", {31'd0, in_handler}, 32'd0);

    // External interrupt with EX at 0x200: exact latency checked by scoreboard
    set_in(1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
    ext_irq = 1'b1;
    expect_pulse(mk(1, 1, 0, 1, 32'h200, 32'h1), IRQ_LAT + 1);
    step(IRQ_LAT + 2);
    ext_irq = 1'b0;
    set_in(1'b1, 1'b1, 32'h250, 1'b0, 1'b0, 1'b1);
    fire(mk(0, 0, 1, 0, 32'h200, 32'h1));

    // Interrupt rising while in the handler is masked until after MRET
    set_in(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    fire(mk(1, 0, 0, 1, 32'h304, 32'h8));
    ext_irq = 1'b1;
    step(IRQ_LAT + 3);
    ext_irq = 1'b0;
    set_in(1'b1, 1'b1, 32'h308, 1'b0, 1'b0, 1'b1);
    expect_pulse(mk(0, 0, 1, 0, 32'h304, 32'h8), 1);
    step(1);
    set_in(1'b1, 1'b0, 32'h400, 1'b0, 1'b0, 1'b0);
    step(1);  // mret pulse cycle: interrupt must wait
    expect_pulse(mk(1, 1, 0, 1, 32'h400, 32'h1), 1);
    step(1);
    step(1);
    set_in(1'b1, 1'b1, 32'h404, 1'b0, 1'b0, 1'b1);
    fire(mk(0, 0, 1, 0, 32'h400, 32'h1));

    // Interrupt beats a simultaneous illegal; illegal re-presents after return
    ext_irq = 1'b1;
    set_in(1'b0, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0);
    step(IRQ_LAT + 2);
    ext_irq = 1'b0;
    set_in(1'b1, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0);
    fire(mk(1, 1, 0, 1, 32'h500, 32'h1));
    set_in(1'b1, 1'b1, 32'h600, 1'b0, 1'b0, 1'b1);
    fire(mk(0, 0, 1, 0, 32'h500, 32'h1));
    set_in(1'b1, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0);
    fire(mk(1, 0, 0, 1, 32'h504, 32'h2));
    set_in(1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 1'b1);
    fire(mk(0, 0, 1, 0, 32'h504, 32'h2));

    // MRET in S_RUN is illegal
    set_in(1'b1, 1'b1, 32'h800, 1'b0, 1'b0, 1'b1);
    fire(mk(1, 0, 0, 1, 32'h804, 32'h2));
    set_in(1'b1, 1'b1, 32'h900, 1'b0, 1'b0, 1'b1);
    fire(mk(0, 0, 1, 0, 32'h804, 32'h2));

    // ECALL held through a 3-cycle stall: one trap, one cycle after advance
    set_in(1'b0, 1'b1, 32'hA00, 1'b1, 1'b0, 1'b0);
    step(3);
    check("stall_hold_sepc", sepc, 32'h804);
    check("stall_hold_state", {31'd0, in_handler}, 32'd0);
    set_in(1'b1, 1'b1, 32'hA00, 1'b1, 1'b0, 1'b0);
    expect_pulse(mk(1, 0, 0, 1, 32'hA04, 32'h8), 1);
    step(1);
    set_in(1'b0, 1'b1, 32'hA00, 1'b1, 1'b0, 1'b0);  // stall during pulse
    step(1);
    set_in(1'b1, 1'b0, 32'hA00, 1'b0, 1'b0, 1'b0);
    step(1);

    // Nested ECALL at 0xFFFFFFFC wraps sepc to 0; MRET is then a no-op
    set_in(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    fire(mk(1, 0, 0, 1, 32'h0, 32'h8));
    set_in(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
    step(1);
    set_in(1'b1, 1'b0, 32'h24, 1'b0, 1'b0, 1'b0);
    step(1);
    check("mret_noop_in_handler", {31'd0, in_handler}, 32'd1);
    set_in(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    fire(mk(1, 0, 0, 1, 32'h44, 32'h2));

    // Reset mid-handler with an interrupt pending
    ext_irq = 1'b1;
    set_in(1'b0, 1'b0, 32'h80, 1'b0, 1'b0, 1'b0);
    step(IRQ_LAT + 2);
    #2;
    rstn = 1'b0;
    ext_irq = 1'b0;
    #1;
    check("mid_rst_sepc", sepc, 32'd0);
    check("mid_rst_scause", scause, 32'd0);
    check("mid_rst_in_handler", {31'd0, in_handler}, 32'd0);
    check("mid_rst_pulses", {29'd0, trap_req, int_take, mret_take}, 32'd0);
    check("mid_rst_flush", {31'd0, flush}, 32'd0);
    step(2);
    rstn = 1'b1;
    set_in(1'b1, 1'b0, 32'h90, 1'b0, 1'b0, 1'b0);
    step(6);
    check("post_rst_in_handler", {31'd0, in_handler}, 32'd0);
    check("post_rst_scause", scause, 32'd0);

    // Every queued pulse must have been observed
    step(2);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
